// File: rtl/pwm_peripheral.sv
// 16-channel output driver: forced low, forced high, or one shared 8-bit PWM.
// Duty is double-buffered and only loaded at a period boundary.
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

  logic [15:0] presc_q, presc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  duty_q, duty_d;
  logic [15:0] out_q, out_d;
  logic        ps_q, ps_d;

  logic        tick;
  logic        boundary;
  logic        pwm_sig;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    tick     = (presc_q == PS_MAX);
    presc_d  = tick ? 16'd0 : presc_q + 16'd1;
    cnt_d    = tick ? cnt_q + 8'd1 : cnt_q;
    boundary = tick && (cnt_q == 8'hFF);
    duty_d   = boundary ? pwm_duty_cycle : duty_q;
    ps_d     = boundary;
    // 0xFF means full on; otherwise the compare can never reach 100%
    pwm_sig  = (duty_q == 8'hFF) ? 1'b1 : (cnt_q < duty_q);
    out_d    = '0;
    for (int i = 0; i < 16; i++) begin
      out_d[i] = en_out[i] & (en_pwm[i] ? pwm_sig : 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      out_q   <= '0;
      ps_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      out_q   <= out_d;
      ps_q    <= ps_d;
    end
  end

  assign out          = out_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral with PRESCALE=13 (period 3328 clks).
// Each task drives one scenario and checks its own expected values.
module tb_pwm_peripheral;

  localparam int P   = 13;
  localparam int PER = 256 * P;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out;
  logic        period_start;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.PRESCALE(P)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en_reg_out_7_0(eo_lo),
    .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo),
    .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty),
    .out(out),
    .period_start(period_start)
  );

  task automatic wait_ps(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < PER + 10; i++) begin
      @(negedge clk);
      if (period_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Call right after a period_start sample; samples one whole period.
  task automatic run_period(
    input  int         wa,
    input  logic [7:0] da,
    input  int         wb,
    input  logic [7:0] db,
    output int         hi,
    output int         first,
    output int         ps_cnt,
    output bit         ps_last,
    output int         mix_bad
  );
    hi = 0; first = -1; ps_cnt = 0; ps_last = 1'b0; mix_bad = 0;
    for (int i = 1; i <= PER; i++) begin
      @(negedge clk);
      if (i == wa) duty = da;
      if (i == wb) duty = db;
      if (out[0]) begin
        hi++;
        if (first < 0) first = i;
      end
      if (period_start) ps_cnt++;
      if (i == PER) ps_last = period_start;
      if (out[15:8] !== 8'hFF || out[7:0] !== {8{out[0]}}) mix_bad++;
    end
  endtask

  task automatic test_reset;
    int n;
    int nz;
    total++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_init out=%h ps=%b want 0000/0", out, period_start);
    end
    @(negedge clk);
    rst_n = 1'b1;
    eo_lo = 8'hFF; eo_hi = 8'hFF; ep_lo = 8'h00; ep_hi = 8'h00;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (out !== 16'hFFFF) begin
      bad++;
      $display("FAIL static_ffff out=%h want ffff", out);
    end
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      bad++;
      $display("FAIL async_reset out=%h ps=%b want 0000/0", out, period_start);
    end
    ep_lo = 8'hFF; ep_hi = 8'hFF; duty = 8'h80;
    @(negedge clk);
    rst_n = 1'b1;
    n = -1; nz = 0;
    for (int i = 1; i <= PER + 10; i++) begin
      @(negedge clk);
      if (out !== 16'h0000) nz++;
      if (period_start) begin
        n = i;
        break;
      end
    end
    total++;
    if (n != PER) begin
      bad++;
      $display("FAIL first_ps_delay got=%0d want=%0d", n, PER);
    end
    total++;
    if (nz != 0) begin
      bad++;
      $display("FAIL shadow_zero nonzero_cycles=%0d want 0", nz);
    end
  endtask

  task automatic test_static;
    eo_lo = 8'hA5; eo_hi = 8'hA5; ep_lo = 8'h00; ep_hi = 8'h00;
    @(negedge clk);
    total++;
    if (out !== 16'hA5A5) begin
      bad++;
      $display("FAIL static_a5a5 out=%h want a5a5", out);
    end
    eo_lo = 8'h00; eo_hi = 8'h00;
    @(negedge clk);
    total++;
    if (out !== 16'h0000) begin
      bad++;
      $display("FAIL static_off out=%h want 0000", out);
    end
  endtask

  task automatic test_pwm50;
    bit ok, pl;
    int hi, fi, pc, mb;
    eo_lo = 8'h01; eo_hi = 8'h00; ep_lo = 8'h01; ep_hi = 8'h00;
    duty = 8'h80;
    wait_ps(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL pwm50_wait no period_start");
    end
    run_period(-1, 8'h00, -1, 8'h00, hi, fi, pc, pl, mb);
    total++;
    if (hi != 1664) begin
      bad++;
      $display("FAIL pwm50_high got=%0d want=1664", hi);
    end
    total++;
    if (fi != 1) begin
      bad++;
      $display("FAIL pwm50_align first_high=%0d want=1", fi);
    end
    total++;
    if (pc != 1 || pl != 1'b1) begin
      bad++;
      $display("FAIL pwm50_period ps_cnt=%0d last=%b want 1/1", pc, pl);
    end
  endtask

  task automatic test_extremes;
    logic [7:0] dv [3] = '{8'h00, 8'hFF, 8'h01};
    int         ev [3] = '{0, PER, P};
    bit ok, pl;
    int hi, fi, pc, mb;
    for (int k = 0; k < 3; k++) begin
      duty = dv[k];
      wait_ps(ok);
      run_period(-1, 8'h00, -1, 8'h00, hi, fi, pc, pl, mb);
      total++;
      if (!ok || hi != ev[k]) begin
        bad++;
        $display("FAIL extreme_%h high=%0d want=%0d ok=%b", dv[k], hi, ev[k], ok);
      end
    end
  endtask

  task automatic test_deferred;
    bit ok, pl;
    int hi, fi, pc, mb;
    duty = 8'h40;
    wait_ps(ok);
    run_period(1000, 8'hC0, -1, 8'h00, hi, fi, pc, pl, mb);
    total++;
    if (!ok || hi != 832) begin
      bad++;
      $display("FAIL defer_cur high=%0d want=832", hi);
    end
    run_period(-1, 8'h00, -1, 8'h00, hi, fi, pc, pl, mb);
    total++;
    if (hi != 2496) begin
      bad++;
      $display("FAIL defer_next high=%0d want=2496", hi);
    end
    run_period(500, 8'h20, 2000, 8'h60, hi, fi, pc, pl, mb);
    total++;
    if (hi != 2496) begin
      bad++;
      $display("FAIL defer_hold high=%0d want=2496", hi);
    end
    run_period(-1, 8'h00, -1, 8'h00, hi, fi, pc, pl, mb);
    total++;
    if (hi != 1248) begin
      bad++;
      $display("FAIL defer_last high=%0d want=1248", hi);
    end
  endtask

  task automatic test_mixed;
    bit ok, pl;
    int hi, fi, pc, mb;
    eo_lo = 8'hFF; eo_hi = 8'hFF; ep_lo = 8'hFF; ep_hi = 8'h00;
    duty = 8'h40;
    wait_ps(ok);
    run_period(-1, 8'h00, -1, 8'h00, hi, fi, pc, pl, mb);
    total++;
    if (!ok || hi != 832) begin
      bad++;
      $display("FAIL mixed_high high=%0d want=832", hi);
    end
    total++;
    if (mb != 0) begin
      bad++;
      $display("FAIL mixed_channels bad_cycles=%0d want=0", mb);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    eo_lo = 8'h00; eo_hi = 8'h00; ep_lo = 8'h00; ep_hi = 8'h00;
    duty  = 8'h00;
    #12;
    test_reset;
    test_static;
    test_pwm50;
    test_extremes;
    test_deferred;
    test_mixed;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
